wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Wishbone classic bus arbiter between up to N masters (CPU, DMA controller) and the single shared decoded slave bus in `sysctl`. It replaces the fixed CPU-only assignment. It grants the bus round-robin, holds the grant for the whole `cyc` of the granted master, and terminates hung cycles with a timeout ack so unmapped addresses cannot stall a master.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of masters (2..4); index 0 = CPU, 1 = DMA.
- `TIMEOUT`, default 255: cycles of unacked `stb` before forced termination; 0 disables the timeout.
- `TO_DATA`, default 32'hFFFF_FFFF: read data returned on a timed-out cycle.

Ports (clock and reset first):
- `wb_clk_i`  in  1  system clock; one clock, all logic on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `m_adr_i`  in  32*N  master addresses, master k at bits [32k+31:32k].
- `m_dat_i`  in  32*N  master write data.
- `m_sel_i`  in  4*N  byte selects.
- `m_we_i`, `m_stb_i`, `m_cyc_i`  in  N  per-master control.
- `m_dat_o`  out  32  read data, shared by all masters.
- `m_ack_o`  out  N  per-master ack.
- `s_adr_o`, `s_dat_o`  out  32  to slave decode.
- `s_sel_o`  out  4  to slave decode.
- `s_we_o`, `s_stb_o`, `s_cyc_o`  out  1  to slave decode.
- `s_dat_i`  in  32  muxed slave read data.
- `s_ack_i`  in  1  muxed slave ack.
- `grant_o`  out  N  one-hot current grant; all zero when idle.
- `timeout_o`  out  1  one-cycle pulse on forced termination.
- `timeout_cnt_o`  out  16  saturating count of timeouts.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: granted master connected to the slave bus.
  - TOACK: forced ack in progress.
- IDLE:
  - `s_cyc_o`/`s_stb_o` are 0 and all `m_ack_o` are 0.
  - If any `m_cyc_i` is high, pick the first requester searching upward from `last+1` (mod N).
  - Register the pick in `grant_o` and go to BUSY.
- BUSY:
  - `s_*_o` are driven combinationally from the granted master; `s_stb_o = m_stb_i[g]`, `s_cyc_o = m_cyc_i[g]`.
  - `m_ack_o[g] = s_ack_i & m_stb_i[g]`; `m_dat_o = s_dat_i`.
  - Non-granted masters see `ack = 0`.
- Timer:
  - Increments each BUSY cycle with `m_stb_i[g]` high and `s_ack_i` low.
  - Clears on `s_ack_i` or when `stb` is low.
  - When the timer equals `TIMEOUT-1` with `stb` high and no ack, go to TOACK.
- TOACK (one cycle):
  - `s_cyc_o`/`s_stb_o` are forced to 0.
  - `m_ack_o[g] = 1`, `m_dat_o = TO_DATA`, `timeout_o = 1`.
  - `timeout_cnt_o` increments, saturating at 16'hFFFF.
  - Next state is BUSY.
- Release: in BUSY, when `m_cyc_i[g]` is low, go to IDLE, set `last <= g` and clear `grant_o`.
- Simultaneous events:
  - `s_ack_i` in the same cycle the timer reaches its limit: the real ack wins and no timeout occurs.
  - A new request in the release cycle waits for IDLE.
- No preemption: a master keeps the bus for its full `cyc`, including multi-beat `cyc` with gaps in `stb`.

## Timing
- Reset values:
  - state IDLE, `grant_o = 0`, `last = N_MASTERS-1` (master 0 wins first).
  - timer 0, `timeout_o = 0`, `timeout_cnt_o = 0`.
  - all `s_*_o` controls and `m_ack_o` are 0.
- Reset mid-cycle: the bus drops at the next edge and no ack is issued.
- Arbitration latency: `m_cyc_i` high at cycle t gives `s_cyc_o` high at t+1.
- Ack path: slave ack to master ack is combinational, 0 cycles.
- Turnaround: exactly one IDLE cycle between consecutive grants.
- Timeout: the forced ack occurs on cycle t+TIMEOUT for `stb` first seen in BUSY at cycle t.

## Structure
- Package `wb_arbiter_pkg`: state enum (IDLE/BUSY/TOACK), `TIMER_W = 16`, `TO_DATA_DEFAULT`.
- Sub-module `rr_pick`: combinational round-robin picker; inputs are the request vector and the last grant, output is a one-hot pick plus a valid flag.
- Registered grant and output muxes stay in `wb_arbiter`.

## Test plan
- Single master: CPU reads address 0x10 with slave ack at 2 cycles.
  - Required: `s_cyc_o` at t+1, `m_ack_o = 2'b01` with data 0xDEADBEEF, then grant released.
- Contention: both `cyc` assert in the same cycle after reset.
  - Required: master 0 is granted first; master 1 is granted after master 0 drops `cyc` plus one IDLE cycle.
  - Then both re-request: master 1's turn passes to master 0 (alternation).
- Timeout: `TIMEOUT = 8`, CPU read to an unmapped address with no ack.
  - Required: `m_ack_o[0]` on cycle t+8 with data 0xFFFF_FFFF, `timeout_o` pulses once, `timeout_cnt_o = 1`.
- Race: `s_ack_i` arrives on exactly the limit cycle.
  - Required: slave data is returned, `timeout_o` stays 0, counter unchanged.
- Reset mid-cycle: assert `wb_rst_i` while DMA is granted.
  - Required: next edge gives `grant_o = 0`, `s_cyc_o = 0`, no acks, master 0 is preferred afterward.
- Isolation: non-granted master holds `stb` for 50 cycles.
  - Required: its `m_ack_o` stays 0 throughout.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
//   Shared types and constants for the Wishbone bus arbiter.
//   - arb_state_t     : arbiter FSM state encoding
//   - TIMER_W         : width of the hung-cycle timer
//   - TO_DATA_DEFAULT : read data returned on a forced (timed-out) ack
//   - sat_inc16()     : saturating increment for the timeout counter
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TOACK = 2'd2
  } arb_state_t;

  localparam int          TIMER_W         = 16;
  localparam logic [31:0] TO_DATA_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches upward from the master after
//   the last grant (wrapping mod N) and returns the first requester.
//   Ports:
//     req   in  N  request vector (one bit per master)
//     last  in  N  one-hot last grant
//     pick  out N  one-hot winner (zero when valid is low)
//     valid out 1  at least one requester
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] pick,
  output logic         valid
);

  // Outer loop locates the one-hot last grant so every index below is a
  // constant after unrolling; the inner loop walks last+1 .. last+N.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (last[s]) begin
        for (int i = 1; i <= N; i++) begin
          if (!valid && req[(s + i) % N]) begin
            pick[(s + i) % N] = 1'b1;
            valid             = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Wishbone classic arbiter: round-robin grant among N masters onto one
//   shared slave bus, grant held for the whole cyc, hung cycles terminated
//   with a forced ack after TIMEOUT unacked stb cycles.
//   Ports:
//     wb_clk_i, wb_rst_i             clock, synchronous active-high reset
//     m_adr_i/m_dat_i  [32N]         master address / write data
//     m_sel_i          [4N]          master byte selects
//     m_we_i/m_stb_i/m_cyc_i [N]     master controls
//     m_dat_o [32], m_ack_o [N]      shared read data, per-master ack
//     s_adr_o/s_dat_o/s_sel_o/s_we_o/s_stb_o/s_cyc_o   to slave decode
//     s_dat_i, s_ack_i               from slave decode
//     grant_o [N]                    one-hot grant, zero when idle
//     timeout_o                      pulse on forced termination
//     timeout_cnt_o [16]             saturating timeout count
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no grant; arbitrate among m_cyc_i
//   BUSY  | granted master connected to the slave bus
//   TOACK | one-cycle forced ack with TO_DATA; slave cyc/stb dropped
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int          N_MASTERS = 2,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] TO_DATA   = TO_DATA_DEFAULT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [32*N_MASTERS-1:0] m_adr_i,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  input  logic [4*N_MASTERS-1:0]  m_sel_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel_o,
  output logic                    s_we_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    grant_o,
  output logic                    timeout_o,
  output logic [15:0]             timeout_cnt_o
);

  localparam bit                   TO_EN    = (TIMEOUT != 0);
  // Timer counts down from TIMEOUT-1; reaching zero with stb still
  // unacked is the TIMEOUT-th stalled cycle.
  localparam logic [TIMER_W-1:0]   TMR_LOAD = TO_EN ? TIMER_W'(TIMEOUT - 1) : '0;
  localparam logic [N_MASTERS-1:0] LAST_RST = {1'b1, {(N_MASTERS-1){1'b0}}};

  arb_state_t             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, last_q, pick;
  logic                   pick_vld;
  logic [TIMER_W-1:0]     tmr_q;
  logic [15:0]            to_cnt_q;

  logic                   cyc_g, stb_g, we_g;
  logic [31:0]            adr_g, dat_g;
  logic [3:0]             sel_g;
  logic                   stall, to_hit;

  rr_pick #(.N(N_MASTERS)) u_pick (
    .req   (m_cyc_i),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // AND-OR mux on the one-hot grant; yields zeros when nothing is granted.
  always_comb begin
    cyc_g = |(m_cyc_i & grant_q);
    stb_g = |(m_stb_i & grant_q);
    we_g  = |(m_we_i & grant_q);
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) begin
        adr_g = m_adr_i[32*k +: 32];
        dat_g = m_dat_i[32*k +: 32];
        sel_g = m_sel_i[4*k +: 4];
      end
    end
  end

  assign stall  = stb_g & ~s_ack_i;
  // A real ack in the limit cycle clears stall, so it beats the timeout.
  assign to_hit = TO_EN && (state_q == BUSY) && cyc_g && stall && (tmr_q == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = adr_g;
    s_dat_o   = dat_g;
    s_sel_o   = sel_g;
    m_ack_o   = '0;
    m_dat_o   = s_dat_i;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) state_d = BUSY;
      end
      BUSY: begin
        s_cyc_o = cyc_g;
        s_stb_o = stb_g;
        s_we_o  = we_g;
        m_ack_o = grant_q & {N_MASTERS{s_ack_i & stb_g}};
        if (!cyc_g)      state_d = IDLE;
        else if (to_hit) state_d = TOACK;
      end
      TOACK: begin
        m_ack_o   = grant_q;
        m_dat_o   = TO_DATA;
        timeout_o = 1'b1;
        state_d   = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      grant_q  <= '0;
      last_q   <= LAST_RST;
      tmr_q    <= TMR_LOAD;
      to_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_vld) grant_q <= pick;
        BUSY: if (!cyc_g) begin
          grant_q <= '0;
          last_q  <= grant_q;
        end
        default: ;
      endcase

      if ((state_q == BUSY) && cyc_g && stall && !to_hit)
        tmr_q <= tmr_q - TIMER_W'(1);
      else
        tmr_q <= TMR_LOAD;

      if (state_q == TOACK) to_cnt_q <= sat_inc16(to_cnt_q);
    end
  end

  assign grant_o       = grant_q;
  assign timeout_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int          N  = 2;
  localparam int          TO = 8;
  localparam logic [31:0] TD = 32'hFFFF_FFFF;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [63:0]   m_adr_i, m_dat_i;
  logic [7:0]    m_sel_i;
  logic [1:0]    m_we_i, m_stb_i, m_cyc_i;
  logic [31:0]   m_dat_o;
  logic [1:0]    m_ack_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o, s_stb_o, s_cyc_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i;
  logic [1:0]    grant_o;
  logic          timeout_o;
  logic [15:0]   timeout_cnt_o;

  wb_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .TO_DATA(TD)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether the forced-ack cycle is
  // running, how many consecutive stalled strobe cycles have been seen.
  int owner   = -1;
  bit forced  = 1'b0;
  int waited  = 0;
  int last    = N - 1;
  int tocount = 0;

  always @(negedge wb_clk_i) begin
    logic [1:0] e_grant, e_ack;
    logic       e_cyc, e_stb, e_to;
    e_grant = '0; e_ack = '0; e_cyc = 1'b0; e_stb = 1'b0; e_to = 1'b0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      if (forced) begin
        e_ack[owner] = 1'b1;
        e_to         = 1'b1;
      end else begin
        e_cyc        = m_cyc_i[owner];
        e_stb        = m_stb_i[owner];
        e_ack[owner] = s_ack_i & m_stb_i[owner];
      end
    end
    if (chk_en) begin
      chk("m_grant", grant_o, e_grant);
      chk("m_scyc", s_cyc_o, e_cyc);
      chk("m_sstb", s_stb_o, e_stb);
      chk("m_ack", m_ack_o, e_ack);
      chk("m_timeout", timeout_o, e_to);
      chk("m_tocnt", timeout_cnt_o, tocount);
      if (owner >= 0 && !forced) begin
        chk("m_sadr", s_adr_o, m_adr_i[32*owner +: 32]);
        chk("m_swdat", s_dat_o, m_dat_i[32*owner +: 32]);
        chk("m_ssel", s_sel_o, m_sel_i[4*owner +: 4]);
        chk("m_swe", s_we_o, m_we_i[owner]);
      end
      if (e_ack != 2'b00) chk("m_rdat", m_dat_o, forced ? TD : s_dat_i);
    end
    if (wb_rst_i) begin
      owner = -1; forced = 1'b0; waited = 0; last = N - 1; tocount = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (owner < 0 && m_cyc_i[(last + k) % N]) owner = (last + k) % N;
      waited = 0;
    end else if (forced) begin
      forced = 1'b0;
      waited = 0;
      if (tocount < 65535) tocount++;
    end else if (!m_cyc_i[owner]) begin
      last   = owner;
      owner  = -1;
      waited = 0;
    end else if (m_stb_i[owner] && !s_ack_i) begin
      waited++;
      if (waited == TO) begin
        forced = 1'b1;
        waited = 0;
      end
    end else begin
      waited = 0;
    end
  end

  task automatic cyc_edge();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge wb_clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int ack_pct;
    wb_rst_i = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_we_i = '0; m_stb_i = '0; m_cyc_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0;
    repeat (2) cyc_edge();
    chk_en = 1'b1;
    at_neg();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_ack", m_ack_o, 2'b00);
    chk("rst_tocnt", timeout_cnt_o, 16'd0);

    // Single master read at 0x10, slave acks two cycles after the request.
    cyc_edge(); wb_rst_i = 1'b0;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h10;
    at_neg();
    chk("t1_idle_scyc", s_cyc_o, 1'b0);
    cyc_edge(); at_neg();
    chk("t1_scyc", s_cyc_o, 1'b1);
    chk("t1_adr", s_adr_o, 32'h10);
    chk("t1_grant", grant_o, 2'b01);
    cyc_edge(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; at_neg();
    chk("t1_ack", m_ack_o, 2'b01);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    cyc_edge(); s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00; at_neg();
    chk("t1_release_scyc", s_cyc_o, 1'b0);
    cyc_edge(); at_neg();
    chk("t1_released", grant_o, 2'b00);

    // Contention right after reset, then alternation.
    wb_rst_i = 1'b1; cyc_edge(); wb_rst_i = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    at_neg(); chk("c_idle", grant_o, 2'b00);
    cyc_edge(); at_neg(); chk("c_first", grant_o, 2'b01);
    cyc_edge(); s_ack_i = 1'b1; at_neg(); chk("c_ack_only0", m_ack_o, 2'b01);
    cyc_edge(); s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10; at_neg();
    chk("c_release", grant_o, 2'b01);
    cyc_edge(); at_neg(); chk("c_turnaround", grant_o, 2'b00);
    chk("c_turn_scyc", s_cyc_o, 1'b0);
    cyc_edge(); at_neg(); chk("c_second", grant_o, 2'b10);
    cyc_edge(); m_cyc_i = 2'b11; m_stb_i = 2'b11; at_neg();
    chk("c_no_preempt", grant_o, 2'b10);
    cyc_edge(); m_cyc_i = 2'b01; m_stb_i = 2'b01; at_neg();
    chk("c_rel1", grant_o, 2'b10);
    cyc_edge(); at_neg(); chk("c_turn2", grant_o, 2'b00);
    cyc_edge(); at_neg(); chk("c_alternate", grant_o, 2'b01);
    cyc_edge(); m_cyc_i = 2'b00; m_stb_i = 2'b00;
    cyc_edge(); cyc_edge();

    // Timeout: unmapped CPU read, no slave ack.
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'hBAD0_0000;
    n = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      at_neg();
      if (timeout_o) pulses++;
      if (m_ack_o[0]) begin
        n = c;
        break;
      end
      cyc_edge();
    end
    chk("to_latency", n, 32'd9);
    chk("to_dat", m_dat_o, 32'hFFFF_FFFF);
    chk("to_pulse", timeout_o, 1'b1);
    cyc_edge(); m_cyc_i = 2'b00; m_stb_i = 2'b00; at_neg();
    if (timeout_o) pulses++;
    chk("to_pulses", pulses, 32'd1);
    chk("to_cnt", timeout_cnt_o, 16'd1);
    cyc_edge(); cyc_edge();

    // Race: real ack arrives on the limit cycle.
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      s_ack_i = (c == 8);
      s_dat_i = 32'h1234_5678;
      if (c >= 9) begin
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
      end
      at_neg();
      if (timeout_o) pulses++;
      if (c == 8) begin
        chk("race_ack", m_ack_o, 2'b01);
        chk("race_dat", m_dat_o, 32'h1234_5678);
      end
      cyc_edge();
    end
    s_ack_i = 1'b0;
    chk("race_pulses", pulses, 32'd0);
    chk("race_cnt", timeout_cnt_o, 16'd1);

    // Reset while DMA is granted.
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    cyc_edge(); at_neg(); chk("rm_dma_grant", grant_o, 2'b10);
    cyc_edge(); wb_rst_i = 1'b1; at_neg();
    cyc_edge(); wb_rst_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    at_neg();
    chk("rm_grant", grant_o, 2'b00);
    chk("rm_scyc", s_cyc_o, 1'b0);
    chk("rm_ack", m_ack_o, 2'b00);
    chk("rm_cnt", timeout_cnt_o, 16'd0);
    cyc_edge(); s_ack_i = 1'b0; at_neg();
    chk("rm_pref0", grant_o, 2'b01);

    // Isolation: master 1 strobes for 50 cycles while master 0 owns the bus.
    for (int c = 0; c < 50; c++) begin
      cyc_edge();
      m_cyc_i    = 2'b11;
      m_stb_i[1] = 1'b1;
      m_stb_i[0] = 1'($urandom);
      s_ack_i    = 1'($urandom);
      s_dat_i    = $urandom;
      at_neg();
      chk("iso_ack1", m_ack_o[1], 1'b0);
      chk("iso_grant", grant_o, 2'b01);
    end
    cyc_edge(); m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = 1'b0;
    cyc_edge(); cyc_edge();

    // Random traffic against the model.
    ack_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      cyc_edge();
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 0;
          1:       ack_pct = 20;
          default: ack_pct = 60;
        endcase
      end
      wb_rst_i = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < N; k++) begin
        if (!m_cyc_i[k]) m_cyc_i[k] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 9) == 0) m_cyc_i[k] = 1'b0;
        m_stb_i[k] = m_cyc_i[k] & ($urandom_range(0, 9) < 7);
        m_we_i[k]  = 1'($urandom);
        m_adr_i[32*k +: 32] = $urandom;
        m_dat_i[32*k +: 32] = $urandom;
        m_sel_i[4*k +: 4]   = 4'($urandom);
      end
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      s_dat_i = $urandom;
    end
    cyc_edge();
    wb_rst_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
    repeat (3) cyc_edge();
    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
